// File: rtl/masked_sbox_scheduler.sv
// rtl/masked_sbox_scheduler.sv - streams a two-share AES state bytewise through a shared masked S-box (option: SBOX_SCHED_ZEROIZE_EN)
module masked_sbox_scheduler #(
    parameter int NBYTES  = 16,
    parameter int LATENCY = 2,
    parameter int RND_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [8*NBYTES-1:0] state0_in,
    input  logic [8*NBYTES-1:0] state1_in,
    input  logic [RND_W-1:0]    rnd_in,
    input  logic                rnd_valid,
    output logic                rnd_ack,
    output logic [7:0]          sbox_in0,
    output logic [7:0]          sbox_in1,
    output logic [RND_W-1:0]    sbox_r,
    input  logic [7:0]          sbox_out0,
    input  logic [7:0]          sbox_out1,
    output logic [8*NBYTES-1:0] state0_out,
    output logic [8*NBYTES-1:0] state1_out,
    output logic                busy,
    output logic                done
);
    localparam int PW = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t              state, state_next;
    logic [8*NBYTES-1:0] copy0, copy1;
    logic [PW-1:0]       issue_ptr, cap_ptr;
    logic [LATENCY-1:0]  vpipe;
    logic                issue, capture;
    logic [7:0]          byte0, byte1;
`ifndef SBOX_SCHED_ZEROIZE_EN
    logic [7:0]          last0, last1;
`endif

    // A byte is issued only when a fresh randomness word is present; the
    // tail of the valid pipe marks the cycle its S-box result arrives.
    assign issue   = (state == FEED) && rnd_valid;
    assign capture = vpipe[LATENCY-1];
    assign busy    = (state == FEED) || (state == DRAIN);
    assign done    = (state == DONE);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM next-state: feed all bytes, wait for the pipe to drain, pulse done
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = FEED;
            FEED:  if (issue && issue_ptr == PW'(NBYTES - 1)) state_next = DRAIN;
            DRAIN: if (capture && cap_ptr == PW'(NBYTES - 1)) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Select the byte pair at issue_ptr; shares stay in separate muxes
    always_comb begin
        byte0 = '0;
        byte1 = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (issue_ptr == PW'(i)) begin
                byte0 = copy0[8*i +: 8];
                byte1 = copy1[8*i +: 8];
            end
        end
    end

    // S-box drive: issue cycles carry the byte; otherwise zero or held value
    always_comb begin
        rnd_ack = issue;
        sbox_r  = issue ? rnd_in : '0;
        if (issue) begin
            sbox_in0 = byte0;
            sbox_in1 = byte1;
`ifdef SBOX_SCHED_ZEROIZE_EN
        end else begin
            sbox_in0 = 8'h00;
            sbox_in1 = 8'h00;
        end
`else
        end else if (state == FEED) begin
            sbox_in0 = 8'h00;
            sbox_in1 = 8'h00;
        end else begin
            sbox_in0 = last0;
            sbox_in1 = last1;
        end
`endif
    end

    // Datapath: input copies, pointers, valid pipe and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            copy0      <= '0;
            copy1      <= '0;
            issue_ptr  <= '0;
            cap_ptr    <= '0;
            vpipe      <= '0;
            state0_out <= '0;
            state1_out <= '0;
`ifndef SBOX_SCHED_ZEROIZE_EN
            last0      <= '0;
            last1      <= '0;
`endif
        end else begin
            vpipe <= (vpipe << 1) | LATENCY'(issue);
            if (state == IDLE && start) begin
                copy0     <= state0_in;
                copy1     <= state1_in;
                issue_ptr <= '0;
                cap_ptr   <= '0;
            end
`ifdef SBOX_SCHED_ZEROIZE_EN
            if (state == DONE) begin
                copy0 <= '0;
                copy1 <= '0;
            end
`endif
            if (issue) begin
                issue_ptr <= issue_ptr + 1'b1;
`ifndef SBOX_SCHED_ZEROIZE_EN
                last0     <= byte0;
                last1     <= byte1;
`endif
            end
            if (capture) begin
                cap_ptr <= cap_ptr + 1'b1;
                for (int i = 0; i < NBYTES; i++) begin
                    if (cap_ptr == PW'(i)) begin
                        state0_out[8*i +: 8] <= sbox_out0;
                        state1_out[8*i +: 8] <= sbox_out1;
                    end
                end
            end
        end
    end
endmodule
